// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: track/hold, per-bit DAC trial, result capture.
// Optional SAR_SETTLE_EN adds a WAIT state of SETTLE_CYC cycles between SET and EVAL.
module sar_adc_ctrl #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned SAMPLE_CYC = 4,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             cmp_in_i,
  output logic             sample_o,
  output logic [WIDTH-1:0] dac_code_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] dout_o
);

  localparam int unsigned IdxW = $clog2(WIDTH);
  localparam int unsigned SmpW = $clog2(SAMPLE_CYC + 1);

  if (WIDTH < 2 || SAMPLE_CYC < 1 || SETTLE_CYC < 1) begin : g_param_check
    $error("sar_adc_ctrl: WIDTH >= 2, SAMPLE_CYC >= 1 and SETTLE_CYC >= 1 required");
  end

`ifdef SAR_SETTLE_EN
  localparam int unsigned SetW = $clog2(SETTLE_CYC + 1);
  typedef enum logic [2:0] {StIdle, StSample, StSet, StWait, StEval, StDone} state_e;
  logic [SetW-1:0] set_cnt_q, set_cnt_d;
`else
  typedef enum logic [2:0] {StIdle, StSample, StSet, StEval, StDone} state_e;
`endif

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [SmpW-1:0]  smp_cnt_q, smp_cnt_d;
  logic [WIDTH-1:0] dac_q, dac_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] bit_mask;

  assign bit_mask = {{(WIDTH-1){1'b0}}, 1'b1} << idx_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      smp_cnt_q <= '0;
      dac_q     <= '0;
      dout_q    <= '0;
`ifdef SAR_SETTLE_EN
      set_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      smp_cnt_q <= smp_cnt_d;
      dac_q     <= dac_d;
      dout_q    <= dout_d;
`ifdef SAR_SETTLE_EN
      set_cnt_q <= set_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    smp_cnt_d = smp_cnt_q;
    dac_d     = dac_q;
    dout_d    = dout_q;
`ifdef SAR_SETTLE_EN
    set_cnt_d = set_cnt_q;
`endif
    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d   = StSample;
          dac_d     = '0;
          smp_cnt_d = '0;
        end
      end
      StSample: begin
        if (smp_cnt_q == SmpW'(SAMPLE_CYC - 1)) begin
          state_d = StSet;
          idx_d   = IdxW'(WIDTH - 1);
        end else begin
          smp_cnt_d = smp_cnt_q + 1'b1;
        end
      end
      StSet: begin
        dac_d = dac_q | bit_mask;
`ifdef SAR_SETTLE_EN
        state_d   = StWait;
        set_cnt_d = '0;
`else
        state_d = StEval;
`endif
      end
`ifdef SAR_SETTLE_EN
      StWait: begin
        if (set_cnt_q == SetW'(SETTLE_CYC - 1)) begin
          state_d = StEval;
        end else begin
          set_cnt_d = set_cnt_q + 1'b1;
        end
      end
`endif
      StEval: begin
        if (!cmp_in_i) begin
          dac_d = dac_q & ~bit_mask;
        end
        if (idx_q == '0) begin
          // Capture here so dout is already valid during the DONE cycle.
          state_d = StDone;
          dout_d  = dac_d;
        end else begin
          state_d = StSet;
          idx_d   = idx_q - 1'b1;
        end
      end
      StDone: begin
        if (start_i) begin
          state_d   = StSample;
          dac_d     = '0;
          smp_cnt_d = '0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign sample_o   = (state_q == StSample);
  assign busy_o     = (state_q != StIdle) && (state_q != StDone);
  assign done_o     = (state_q == StDone);
  assign dac_code_o = dac_q;
  assign dout_o     = dout_q;

endmodule
